// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle add/sub/logic/compare ops with a valid/ready handshake.
// Define ALU_EXEC_MULT_EN to build the iterative shift-add multiplier (funct 011000).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             err_r;

  logic [WIDTH-1:0] res_s;
  logic             err_s;
  logic             mul_s;
  logic             idle_s;
  logic             done_s;
  logic             accept_s;
  logic [WIDTH-1:0] mul_res_s;

  assign accept_s  = in_valid && in_ready;
  assign in_ready  = idle_s && !reset && (!out_valid_r || out_ready);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign err       = err_r;

  // Operation decode; anything unlisted is illegal and yields result 0 with err set
  always_comb begin
    res_s = {WIDTH{1'b0}};
    err_s = 1'b0;
    mul_s = 1'b0;
    case (alu_op)
      2'b00: res_s = a + b;
      2'b01: res_s = a - b;
      2'b10: begin
        case (funct)
          6'b100000: res_s = a + b;
          6'b100010: res_s = a - b;
          6'b100100: res_s = a & b;
          6'b100101: res_s = a | b;
          6'b100110: res_s = a ^ b;
          6'b100111: res_s = ~(a | b);
          6'b101010: res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          6'b101011: res_s = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_EXEC_MULT_EN
          6'b011000: mul_s = 1'b1;
`endif
          default:   err_s = 1'b1;
        endcase
      end
      default: err_s = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MULT_EN
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             last_step_s;

  assign last_step_s = (cnt_r == CW'(WIDTH - 1));
  assign idle_s      = (state_r == IDLE);
  assign done_s      = (state_r == DONE);
  assign mul_res_s   = acc_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && mul_s) begin
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (last_step_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MUL;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Shift-add multiplier: one partial product per cycle, low WIDTH bits kept
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (idle_s && accept_s && mul_s) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else if (state_r == MUL) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
    end
  end
`else
  assign idle_s    = 1'b1;
  assign done_s    = 1'b0;
  assign mul_res_s = {WIDTH{1'b0}};
`endif

  // Output register: new single-cycle result, finished product, or consume
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
    end else if (accept_s && !mul_s) begin
      out_valid_r <= 1'b1;
      result_r    <= res_s;
      zero_r      <= (res_s == {WIDTH{1'b0}});
      err_r       <= err_s;
    end else if (done_s) begin
      out_valid_r <= 1'b1;
      result_r    <= mul_res_s;
      zero_r      <= (mul_res_s == {WIDTH{1'b0}});
      err_r       <= 1'b0;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized bench for alu_exec_unit against a transaction-level reference model.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: presented output plus remaining multiply latency
  logic         m_valid  = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_zero   = 1'b0;
  logic         m_err    = 1'b0;
  int           m_busy   = 0;
  logic [W-1:0] m_mul    = '0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic e, output logic m);
    longint sx;
    longint sy;
    r = '0;
    e = 1'b0;
    m = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == 2'd0) r = x + y;
    else if (op == 2'd1) r = x - y;
    else if (op == 2'd3) e = 1'b1;
    else begin
      case (fn)
        6'd32:   r = x + y;
        6'd34:   r = x - y;
        6'd36:   r = x & y;
        6'd37:   r = x | y;
        6'd38:   r = x ^ y;
        6'd39:   r = ~(x | y);
        6'd42:   r = (sx < sy) ? 32'd1 : 32'd0;
        6'd43:   r = (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_MULT_EN
        6'd24: begin
          m = 1'b1;
          r = W'(64'(x) * 64'(y));
        end
`endif
        default: e = 1'b1;
      endcase
    end
  endfunction

  // One clock cycle: drive, check in_ready, advance the model, check outputs
  task automatic step(input logic rst, input logic iv, input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] av, input logic [W-1:0] bv, input logic ordy);
    logic         exp_rdy;
    logic [W-1:0] r;
    logic         e;
    logic         m;
    reset     = rst;
    in_valid  = iv;
    alu_op    = op;
    funct     = fn;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    exp_rdy = !rst && (m_busy == 0) && (!m_valid || ordy);
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    @(posedge clk);
    ref_op(op, fn, av, bv, r, e, m);
    if (rst) begin
      m_valid = 1'b0; m_result = '0; m_zero = 1'b0; m_err = 1'b0; m_busy = 0;
    end else if (iv && exp_rdy && m) begin
      m_busy = W + 1;
      m_mul  = r;
      if (ordy) m_valid = 1'b0;
    end else if (iv && exp_rdy) begin
      m_valid = 1'b1; m_result = r; m_zero = (r == '0); m_err = e;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1; m_result = m_mul; m_zero = (m_mul == '0); m_err = 1'b0;
      end
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid) begin
      check_eq("result", {32'd0, result}, {32'd0, m_result});
      check_eq("zero", {63'd0, zero}, {63'd0, m_zero});
      check_eq("err", {63'd0, err}, {63'd0, m_err});
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] fn_tab [10] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd24, 6'd0};

  initial begin
    logic [5:0]   fn;
    logic [W-1:0] x;
    logic [W-1:0] y;
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'd0; funct = 6'd0; a = '0; b = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 2'd0, 6'd0, 32'd1, 32'd1, 1'b1);
    step(1'b1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b0);
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);

    step(1'b0, 1'b1, 2'd0, 6'd0, 32'd5, 32'd7, 1'b1);
    check_eq("add_5_7", {32'd0, result}, 64'd12);
    check_eq("add_zero", {63'd0, zero}, 64'd0);
    step(1'b0, 1'b1, 2'd2, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check_eq("slt_neg", {32'd0, result}, 64'd1);
    step(1'b0, 1'b1, 2'd2, 6'b101011, 32'hFFFF_FFFF, 32'd1, 1'b1);
    check_eq("sltu_big", {32'd0, result}, 64'd0);
    step(1'b0, 1'b1, 2'd1, 6'd0, 32'h1234, 32'h1234, 1'b1);
    check_eq("sub_eq_zero", {63'd0, zero}, 64'd1);
    step(1'b0, 1'b1, 2'd3, 6'd0, 32'd9, 32'd9, 1'b1);
    check_eq("illegal_err", {63'd0, err}, 64'd1);
    check_eq("illegal_res", {32'd0, result}, 64'd0);
    step(1'b0, 1'b1, 2'd2, 6'b100111, 32'd0, 32'd0, 1'b1);
    check_eq("nor_err_clr", {63'd0, err}, 64'd0);
`ifndef ALU_EXEC_MULT_EN
    step(1'b0, 1'b1, 2'd2, 6'b011000, 32'd3, 32'd4, 1'b1);
    check_eq("mult_illegal", {63'd0, err}, 64'd1);
`endif

    // Backpressure hold, then back-to-back accept on release
    step(1'b0, 1'b1, 2'd0, 6'd0, 32'd1, 32'd2, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd0, 6'd0, 32'd9, 32'd9, 1'b0);
    check_eq("hold_result", {32'd0, result}, 64'd3);
    step(1'b0, 1'b1, 2'd0, 6'd0, 32'd100, 32'd1, 1'b1);
    check_eq("b2b_result", {32'd0, result}, 64'd101);
    check_eq("b2b_valid", {63'd0, out_valid}, 64'd1);

`ifdef ALU_EXEC_MULT_EN
    step(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 2'd2, 6'b011000, 32'h10001, 32'h10001, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b1, 2'd0, 6'd0, 32'd1, 32'd1, 1'b1);
      check_eq("mul_wait", {63'd0, out_valid}, 64'd0);
    end
    step(1'b0, 1'b1, 2'd0, 6'd0, 32'd1, 32'd1, 1'b0);
    check_eq("mul_result", {32'd0, result}, 64'h0002_0001);
    step(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 2'd2, 6'b011000, 32'd7, 32'd9, 1'b1);
    for (int k = 1; k < 10; k++) step(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1);
    check_eq("abort_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1);
`endif

    for (int i = 0; i < 1500; i++) begin
      fn = ($urandom_range(0, 9) == 9) ? 6'($urandom) : fn_tab[$urandom_range(0, 9)];
      x  = rnd_operand();
      y  = ($urandom_range(0, 7) == 0) ? x : rnd_operand();
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           fn, x, y, ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 8..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present on alu_op/funct/a/b.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 alu_op  input  2  00 add (LW/SW), 01 sub (BEQ), 10 R-type decode via funct, 11 illegal.
REQ-007 funct  input  6  R-type function field.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result/zero/err valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  WIDTH  registered operation result.
REQ-012 zero  output  1  registered flag, result == 0.
REQ-013 err  output  1  registered flag, request was an illegal encoding.

Function
REQ-014 Accept occurs on a rising edge where in_valid && in_ready; a/b/alu_op/funct are sampled only then.
REQ-015 in_ready = state IDLE && !reset && (!out_valid || out_ready).
REQ-016 R-type decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt signed, 101011 sltu unsigned, 011000 mult (low WIDTH bits of a*b).
REQ-017 add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-018 slt/sltu produce 1 or 0 zero-extended to WIDTH.
REQ-019 Single-cycle ops: out_valid rises on the accepting edge (latency 1); state stays IDLE.
REQ-020 Illegal encodings (alu_op 11, unlisted funct): latency 1, result 0, zero 1, err 1; never X.
REQ-021 FSM states: IDLE, MUL, DONE. IDLE->MUL on accepting mult; MUL iterates one shift-add step per cycle for WIDTH cycles; MUL->DONE after the last step; DONE->IDLE when the result is presented.
REQ-022 Mult latency: out_valid rises exactly WIDTH+1 edges after the accepting edge; in_ready is 0 throughout MUL and DONE.
REQ-023 out_valid, result, zero, err hold stable while out_valid && !out_ready.
REQ-024 out_valid clears on an edge with out_ready high unless a new request is accepted on the same edge, in which case the new single-cycle result replaces the old one (back-to-back throughput 1/cycle).
REQ-025 A mult result arriving while the previous result is unconsumed cannot occur (REQ-015 guarantees output free before accept).
REQ-026 err clears with every newly presented result that is legal.

Reset
REQ-027 On reset edge: state IDLE, out_valid 0, result 0, zero 0, err 0, multiplier accumulator/counter 0.
REQ-028 Reset asserted mid-multiply aborts the operation; no result is ever presented for it.
REQ-029 in_ready is 0 during any cycle with reset high.

Configuration
REQ-030 Macro ALU_EXEC_MULT_EN: when defined, mult (funct 011000) is implemented per REQ-021/022.
REQ-031 When ALU_EXEC_MULT_EN is undefined: no MUL/DONE states or multiplier datapath are built; funct 011000 is illegal per REQ-020.

Verification
REQ-032 WIDTH=32, alu_op 00, a=5, b=7 -> next edge out_valid 1, result 12, zero 0, err 0.
REQ-033 alu_op 10 funct 101010, a=0xFFFFFFFF, b=1 -> result 1; same with funct 101011 -> result 0.
REQ-034 alu_op 01, a=b=0x1234 -> result 0, zero 1; alu_op 11 -> result 0, err 1.
REQ-035 MULT_EN defined, funct 011000, a=0x10001, b=0x10001 -> in_ready 0 for 33 cycles, out_valid at edge 33, result 0x00020001.
REQ-036 out_ready held 0 for 5 cycles after a result -> outputs stable, in_ready 0; then out_ready 1 with new add accepted same edge -> new result next cycle, no gap.
REQ-037 reset pulsed at MUL step 10 -> out_valid stays 0, in_ready 1 first cycle after reset deasserts.
